// File: rtl/card_dealer_pkg.sv
// Shared constants, FSM state type and seed generator for the card dealer.
package card_dealer_pkg;

   localparam int DECK_SIZE = 52;
   localparam int CARD_W    = 6;
   localparam int SEED_W    = 16;

   typedef enum logic {
      IDLE = 1'b0,
      ROLL = 1'b1
   } state_e;

   // seed ^ rotl(seed, 1); collapses to zero only for all-0 / all-1 seeds
   function automatic logic [SEED_W-1:0] xorshift_next(input logic [SEED_W-1:0] seed,
                                                       input logic [SEED_W-1:0] seed_dflt);
      logic [SEED_W-1:0] nxt;
      nxt = seed ^ {seed[SEED_W-2:0], seed[SEED_W-1]};
      return (nxt == '0) ? seed_dflt : nxt;
   endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/grant and card delivery bundle between requesters (master) and the dealer (slave).
interface card_dealer_if #(
   parameter int NUM_REQ = 4
);
   logic [15:0]        seed_in;
   logic               seed_load;
   logic               shuffle;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic               card_valid;
   logic [5:0]         card_id;
   logic [2:0]         card_owner;
   logic [5:0]         cards_left;
   logic               deck_empty;
   logic               busy;

   modport master (
      output seed_in, seed_load, shuffle, req,
      input  gnt, card_valid, card_id, card_owner, cards_left, deck_empty, busy
   );

   modport slave (
      input  seed_in, seed_load, shuffle, req,
      output gnt, card_valid, card_id, card_owner, cards_left, deck_empty, busy
   );
endinterface

// File: rtl/card_dealer_rr_arb.sv
// Round-robin arbiter: first active request at or after ptr wins (one-hot + index).
module card_dealer_rr_arb #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         ptr,
   output logic [NUM_REQ-1:0] gnt_oh,
   output logic [2:0]         gnt_idx,
   output logic               any
);
   int cand;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      any     = 1'b0;
      cand    = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr) + i) % NUM_REQ;
         if (!any && req[cand]) begin
            any          = 1'b1;
            gnt_oh[cand] = 1'b1;
            gnt_idx      = 3'(cand);
         end
      end
   end
endmodule

// File: rtl/card_dealer.sv
// Unique-card dealer: round-robin grants, one partial Fisher-Yates step per deal.
// Define CARD_DEALER_AUTOSHUFFLE_EN to refill an empty deck on the next granted request.
//
// state | meaning
// IDLE  | accept shuffle / seed load / arbitrate requests
// ROLL  | draw deck[seed % cards_left], move last live card into the hole
module card_dealer
   import card_dealer_pkg::*;
#(
   parameter int                NUM_REQ      = 4,
   parameter logic [SEED_W-1:0] SEED_DEFAULT = 16'hACE1
) (
   input logic          clock,
   input logic          resetn,
   card_dealer_if.slave dif
);
   state_e              state_q, state_d;
   logic [SEED_W-1:0]   seed_q, seed_d;
   logic [2:0]          ptr_q, ptr_d;
   logic [2:0]          owner_q, owner_d;
   logic [2:0]          card_owner_q, card_owner_d;
   logic [CARD_W-1:0]   cards_left_q, cards_left_d;
   logic [CARD_W-1:0]   card_id_q, card_id_d;
   logic [CARD_W-1:0]   deck_q [DECK_SIZE];
   logic [CARD_W-1:0]   deck_d [DECK_SIZE];
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic                card_valid_q, card_valid_d;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [2:0]          arb_idx;
   logic                arb_any;
   logic [SEED_W-1:0]   divisor;
   logic [CARD_W-1:0]   roll_idx;
   logic [CARD_W-1:0]   last_idx;
   logic                deal_ok;
   logic                restore;

   card_dealer_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (dif.req),
      .ptr     (ptr_q),
      .gnt_oh  (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   // divisor guard only matters off the ROLL path, where cards_left is never 0
   assign divisor  = (cards_left_q == '0) ? SEED_W'(1) : SEED_W'(cards_left_q);
   assign roll_idx = CARD_W'(seed_q % divisor);
   assign last_idx = cards_left_q - CARD_W'(1);

`ifdef CARD_DEALER_AUTOSHUFFLE_EN
   assign deal_ok        = arb_any;
   assign dif.deck_empty = 1'b0;
`else
   assign deal_ok        = arb_any && (cards_left_q != '0);
   assign dif.deck_empty = (cards_left_q == '0);
`endif

   always_comb begin
      state_d      = state_q;
      seed_d       = seed_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      card_owner_d = card_owner_q;
      cards_left_d = cards_left_q;
      card_id_d    = card_id_q;
      deck_d       = deck_q;
      gnt_d        = '0;
      card_valid_d = 1'b0;
      restore      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dif.shuffle) begin
               restore = 1'b1;
            end else if (dif.seed_load) begin
               seed_d = (dif.seed_in == '0) ? SEED_DEFAULT : dif.seed_in;
            end else if (deal_ok) begin
               gnt_d   = arb_gnt;
               seed_d  = xorshift_next(seed_q, SEED_DEFAULT);
               owner_d = arb_idx;
               ptr_d   = (arb_idx == 3'(NUM_REQ - 1)) ? 3'd0 : arb_idx + 3'd1;
               state_d = ROLL;
`ifdef CARD_DEALER_AUTOSHUFFLE_EN
               restore = (cards_left_q == '0);
`endif
            end
         end
         ROLL: begin
            state_d = IDLE;
            if (dif.shuffle) begin
               restore = 1'b1;
            end else begin
               card_id_d        = deck_q[roll_idx];
               deck_d[roll_idx] = deck_q[last_idx];
               cards_left_d     = last_idx;
               card_valid_d     = 1'b1;
               card_owner_d     = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
      if (restore) begin
         for (int i = 0; i < DECK_SIZE; i++) deck_d[i] = CARD_W'(i + 1);
         cards_left_d = CARD_W'(DECK_SIZE);
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         seed_q       <= SEED_DEFAULT;
         ptr_q        <= '0;
         owner_q      <= '0;
         card_owner_q <= '0;
         cards_left_q <= CARD_W'(DECK_SIZE);
         card_id_q    <= '0;
         gnt_q        <= '0;
         card_valid_q <= 1'b0;
         for (int i = 0; i < DECK_SIZE; i++) deck_q[i] <= CARD_W'(i + 1);
      end else begin
         state_q      <= state_d;
         seed_q       <= seed_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         card_owner_q <= card_owner_d;
         cards_left_q <= cards_left_d;
         card_id_q    <= card_id_d;
         gnt_q        <= gnt_d;
         card_valid_q <= card_valid_d;
         deck_q       <= deck_d;
      end
   end

   assign dif.gnt        = gnt_q;
   assign dif.card_valid = card_valid_q;
   assign dif.card_id    = card_id_q;
   assign dif.card_owner = card_owner_q;
   assign dif.cards_left = cards_left_q;
   assign dif.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with a small reference deck/seed model.
module tb_card_dealer;
   localparam int NUM_REQ = 4;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   card_dealer_if #(.NUM_REQ(NUM_REQ)) dif ();

   card_dealer #(.NUM_REQ(NUM_REQ), .SEED_DEFAULT(16'hACE1)) dut (
      .clock  (clock),
      .resetn (resetn),
      .dif    (dif.slave)
   );

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [15:0] m_seed;
   logic [5:0]  m_deck [52];
   int          m_left;
   logic [63:0] seen;
   logic [5:0]  last_card;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_next(input logic [15:0] s);
      logic [15:0] n;
      n = s ^ {s[14:0], s[15]};
      return (n == 16'h0) ? 16'hACE1 : n;
   endfunction

   task automatic m_restore();
      for (int i = 0; i < 52; i++) m_deck[i] = 6'(i + 1);
      m_left = 52;
   endtask

   // Request with mask; expect a grant on the first sample and a card one cycle later.
   task automatic deal(input logic [3:0] mask, input int exp_owner);
      logic [3:0] g;
      int         k;
      int         idx;
      int         owner;
      logic [5:0] exp_card;
      g = '0;
      k = 0;
      dif.req = mask;
      while (g == '0 && k < 8) begin
         @(negedge clock);
         if (dif.gnt != '0) g = dif.gnt;
         else k++;
      end
      check("gnt_latency", 32'(k), 32'd0);
      if (g == '0) begin
         dif.req = '0;
         return;
      end
      check("gnt", 32'(g), 32'(4'b0001 << exp_owner));
      check("busy_roll", 32'(dif.busy), 32'd1);
      @(negedge clock);
      dif.req = '0;
`ifdef CARD_DEALER_AUTOSHUFFLE_EN
      if (m_left == 0) m_restore();
`endif
      m_seed = m_next(m_seed);
      idx = int'(m_seed) % m_left;
      exp_card = m_deck[idx];
      m_deck[idx] = m_deck[m_left - 1];
      m_left--;
      owner = 0;
      for (int b = 0; b < NUM_REQ; b++) if (g[b]) owner = b;
      check("card_valid", 32'(dif.card_valid), 32'd1);
      check("card_id", 32'(dif.card_id), 32'(exp_card));
      check("cards_left", 32'(dif.cards_left), 32'(m_left));
      check("card_owner", 32'(dif.card_owner), 32'(owner));
      seen[dif.card_id] = 1'b1;
      last_card = dif.card_id;
   endtask

   initial begin
      int gcount;
      dif.seed_in   = '0;
      dif.seed_load = 1'b0;
      dif.shuffle   = 1'b0;
      dif.req       = '0;
      seen          = '0;
      last_card     = '0;
      m_seed        = 16'hACE1;
      m_restore();

      repeat (3) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      check("rst_gnt", 32'(dif.gnt), 32'd0);
      check("rst_card_valid", 32'(dif.card_valid), 32'd0);
      check("rst_card_id", 32'(dif.card_id), 32'd0);
      check("rst_card_owner", 32'(dif.card_owner), 32'd0);
      check("rst_cards_left", 32'(dif.cards_left), 32'd52);
      check("rst_deck_empty", 32'(dif.deck_empty), 32'd0);
      check("rst_busy", 32'(dif.busy), 32'd0);

      // seed 1 -> next seed 3 -> deck[3] = 4; then seed 5 -> deck[5] = 6
      dif.seed_in   = 16'h0001;
      dif.seed_load = 1'b1;
      dif.req       = 4'b0001;
      @(negedge clock);
      check("load_no_gnt", 32'(dif.gnt), 32'd0);
      dif.seed_load = 1'b0;
      dif.req       = '0;
      m_seed        = 16'h0001;
      deal(4'b0001, 0);
      check("first_card", 32'(last_card), 32'd4);
      deal(4'b0001, 0);
      check("second_card", 32'(last_card), 32'd6);
      deal(4'b1000, 3);

      // pointer now back at 0: all four requesting rotates 0,1,2,3,0,1,2,3
      for (int n = 0; n < 8; n++) deal(4'b1111, n % 4);

      while (m_left > 0 && n_mis < 20) deal(4'b0010, 1);
      check("distinct_cards", $countones(seen), 32'd52);
      check("card0_never", 32'(seen[0]), 32'd0);
      check("cards_left_zero", 32'(dif.cards_left), 32'd0);

`ifdef CARD_DEALER_AUTOSHUFFLE_EN
      check("deck_empty_tied", 32'(dif.deck_empty), 32'd0);
      deal(4'b0001, 0);
      check("autoshuffle_left", 32'(dif.cards_left), 32'd51);
      check("deck_empty_tied2", 32'(dif.deck_empty), 32'd0);
`else
      check("deck_empty", 32'(dif.deck_empty), 32'd1);
      dif.req = 4'b0001;
      gcount  = 0;
      repeat (6) begin
         @(negedge clock);
         if (dif.gnt != '0) gcount++;
      end
      dif.req = '0;
      check("empty_no_gnt", 32'(gcount), 32'd0);
      check("empty_busy", 32'(dif.busy), 32'd0);
`endif

      dif.shuffle = 1'b1;
      @(negedge clock);
      dif.shuffle = 1'b0;
      m_restore();
      check("shuffle_left", 32'(dif.cards_left), 32'd52);
      check("shuffle_empty", 32'(dif.deck_empty), 32'd0);

      // shuffle during ROLL aborts the deal; seed has still advanced
      dif.req = 4'b0100;
      gcount  = 0;
      while (dif.gnt == '0 && gcount < 8) begin
         @(negedge clock);
         gcount++;
      end
      check("abort_gnt", 32'(dif.gnt), 32'b0100);
      dif.req     = '0;
      dif.shuffle = 1'b1;
      @(negedge clock);
      dif.shuffle = 1'b0;
      m_seed = m_next(m_seed);
      check("abort_no_valid", 32'(dif.card_valid), 32'd0);
      check("abort_left", 32'(dif.cards_left), 32'd52);
      check("abort_busy", 32'(dif.busy), 32'd0);
      check("card_id_held", 32'(dif.card_id), 32'(last_card));

      // zero seed load falls back to ACE1 -> next F522, 62754 % 52 = 42 -> card 43
      dif.seed_in   = 16'h0000;
      dif.seed_load = 1'b1;
      @(negedge clock);
      dif.seed_load = 1'b0;
      m_seed = 16'hACE1;
      deal(4'b0001, 3 - 3);
      check("zero_seed_card", 32'(last_card), 32'd43);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
